// File: rtl/booth_pkg.sv
// Shared types and defaults for the radix-2 sequential Booth multiplier.
package booth_pkg;

   localparam int unsigned DEF_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/booth.sv
// Radix-2 sequential Booth multiplier: one add/sub-and-shift step per clock,
// signed product registered on completion with a one-cycle done pulse.
module booth
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [WIDTH-1:0]     M,
   input  logic [WIDTH-1:0]     Q,
   input  logic                 start,
   output logic [2*WIDTH-1:0]   result,
   output logic                 busy,
   output logic                 done
);

   // One guard bit on A and M so subtracting the most negative M cannot overflow.
   localparam int unsigned AW = WIDTH + 1;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   state_t               state_q, state_d;
   logic [AW-1:0]        a_q, a_d;
   logic [AW-1:0]        m_q, m_d;
   logic [WIDTH-1:0]     qr_q, qr_d;
   logic                 qm1_q, qm1_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   result_d;
   logic                 busy_d, done_d;
   logic [AW-1:0]        sum;

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      m_d      = m_q;
      qr_d     = qr_q;
      qm1_d    = qm1_q;
      cnt_d    = cnt_q;
      result_d = result;
      busy_d   = busy;
      done_d   = 1'b0;
      sum      = a_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               m_d     = {M[WIDTH-1], M};
               qr_d    = Q;
               a_d     = '0;
               qm1_d   = 1'b0;
               cnt_d   = CW'(WIDTH);
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            unique case ({qr_q[0], qm1_q})
               2'b01:   sum = a_q + m_q;
               2'b10:   sum = a_q - m_q;
               default: sum = a_q;
            endcase
            // Arithmetic right shift of the concatenation {A, Qreg, Q(-1)}.
            a_d   = {sum[AW-1], sum[AW-1:1]};
            qr_d  = {sum[0], qr_q[WIDTH-1:1]};
            qm1_d = qr_q[0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            result_d = {a_q[WIDTH-1:0], qr_q};
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         m_q     <= '0;
         qr_q    <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         result  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         qr_q    <= qr_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         result  <= result_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule

// File: tb/tb_booth.sv
// Self-checking bench for booth: directed corners plus random operands
// compared against plain signed multiplication.
module tb_booth;

   localparam int unsigned W = 6;

   logic              clk = 1'b0;
   logic              n_rst;
   logic [W-1:0]      M, Q;
   logic              start;
   logic [2*W-1:0]    result;
   logic              busy, done;

   int checks   = 0;
   int failures = 0;

   booth #(.WIDTH(W)) dut (
      .clk    (clk),
      .n_rst  (n_rst),
      .M      (M),
      .Q      (Q),
      .start  (start),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b);
      int p;
      p = int'(a) * int'(b);
      return (2*W)'(p);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for done; returns edges seen after the call point.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // One multiplication; optionally pokes a second start with new operands mid-CALC.
   task automatic do_mult(input logic [W-1:0] m, input logic [W-1:0] q,
                          input bit poke, input string tag);
      logic [2*W-1:0] exp;
      int n;
      exp = ref_mul(m, q);
      @(negedge clk);
      M = m; Q = q; start = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_busy_load"}, 64'(busy), 64'(1));
      start = 1'b0;
      M = W'($urandom);
      Q = W'($urandom);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
         if (poke && n == 3) begin
            start = 1'b1;
            M = ~m;
            Q = q + W'(1);
         end else if (poke && n == 4) begin
            start = 1'b0;
         end
      end
      chk({tag, "_latency"}, 64'(n), 64'(W + 1));
      chk({tag, "_result"}, 64'(result), 64'(exp));
      chk({tag, "_busy_end"}, 64'(busy), 64'(0));
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 64'(done), 64'(0));
      chk({tag, "_result_held"}, 64'(result), 64'(exp));
   endtask

   initial begin
      int n;
      n_rst = 1'b0;
      start = 1'b0;
      M = '0;
      Q = '0;
      #3;
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      #4 n_rst = 1'b1;

      do_mult(6'b110100, 6'b011110, 1'b0, "m12x30");
      chk("m12x30_const", 64'(result), 64'(12'hE98));
      do_mult(6'b100000, 6'b100000, 1'b0, "n32xn32");
      chk("n32xn32_const", 64'(result), 64'(12'h400));
      do_mult(6'd31, 6'b100000, 1'b0, "31xn32");
      chk("31xn32_const", 64'(result), 64'(12'hC20));
      do_mult(6'd0, 6'b111111, 1'b0, "0xn1");
      chk("0xn1_const", 64'(result), 64'(12'h000));
      do_mult(6'b111111, 6'b111111, 1'b0, "n1xn1");
      chk("n1xn1_const", 64'(result), 64'(12'h001));

      // Start during CALC must be ignored.
      do_mult(6'd13, 6'b101011, 1'b1, "ignore_start");

      // Reset mid-operation.
      @(negedge clk);
      M = 6'd25; Q = 6'd19; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 n_rst = 1'b0;
      #1;
      chk("midrst_result", 64'(result), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_done", 64'(done), 64'(0));
      @(negedge clk) n_rst = 1'b1;
      do_mult(6'd25, 6'd19, 1'b0, "after_rst");

      // start held high: relaunch at the first idle edge after completion.
      @(negedge clk);
      M = 6'b101101; Q = 6'd7; start = 1'b1;
      wait_done(n);
      chk("held_first", 64'(result), 64'(ref_mul(6'b101101, 6'd7)));
      M = 6'd22; Q = 6'b110011;
      @(posedge clk); #1;
      chk("held_relaunch_busy", 64'(busy), 64'(1));
      start = 1'b0;
      wait_done(n);
      chk("held_second_lat", 64'(n), 64'(W + 1));
      chk("held_second", 64'(result), 64'(ref_mul(6'd22, 6'b110011)));

      for (int i = 0; i < 40; i++) begin
         do_mult(W'($urandom), W'($urandom), 1'b0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/booth.md
BOOTH -- requirements
Module: booth

Interface
REQ-001 Parameter WIDTH, default 6: operand width in bits; result width is 2*WIDTH.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 M  input  WIDTH  multiplicand, two's-complement signed.
REQ-005 Q  input  WIDTH  multiplier, two's-complement signed.
REQ-006 start  input  1  request; sampled high on a rising edge while idle begins one multiplication.
REQ-007 result  output  2*WIDTH  signed product M*Q, registered, held until the next completion.
REQ-008 busy  output  1  high from the load edge until the completion edge.
REQ-009 done  output  1  one-cycle pulse, high in the cycle after result is updated.

Function
REQ-010 The block SHALL implement radix-2 sequential Booth multiplication with an FSM of states IDLE, CALC and DONE.
REQ-011 IDLE, start=1 at edge E0: M and Q SHALL be latched into internal registers; accumulator A=0; Q(-1)=0; counter=WIDTH; state SHALL go to CALC.
REQ-012 CALC, each edge: pair {Q0,Q(-1)}=01 SHALL give A+=M; 10 SHALL give A-=M; 00/11 SHALL leave A unchanged; then {A,Qreg,Q(-1)} SHALL shift right arithmetically by one; counter SHALL decrement.
REQ-013 The CALC state SHALL take exactly WIDTH edges (E1..E6 for WIDTH=6); on the last one the state SHALL go to DONE.
REQ-014 DONE, edge E(WIDTH+1): result SHALL be loaded with {A[WIDTH-1:0],Qreg}; done SHALL be set for one cycle; state SHALL return to IDLE.
REQ-015 Latency: result SHALL be valid after the 7th rising edge following the start sample edge (WIDTH+1 edges).
REQ-016 A and the sign-extended M SHALL be WIDTH+1 bits wide so that M=-2^(WIDTH-1) is subtracted without overflow.
REQ-017 The product SHALL be exact for all operand pairs, including (-32)*(-32)=+1024.
REQ-018 start SHALL be ignored while busy=1; M and Q changes after E0 SHALL NOT affect the product in progress.
REQ-019 start held high SHALL launch a new operation at the first IDLE edge after completion.
REQ-020 result SHALL change only at completion edges or reset.

Reset
REQ-021 n_rst=0 SHALL immediately force state IDLE, result=0, busy=0, done=0, and clear A, Qreg, Q(-1), the M register and the counter, including mid-operation.
REQ-022 After reset release, the first start sampled at a rising edge SHALL begin a fresh operation.

Structure
REQ-023 A shared package SHALL hold the FSM state enum (IDLE, CALC, DONE) and the default WIDTH constant.
REQ-024 The block SHALL be a single module; no sub-module is required.

Verification
REQ-025 Reset low to 7 ps, M=6'b110100 (-12), Q=6'b011110 (30), start pulsed high over one rising edge -> 7 edges later result=12'hE98 (-360), done pulses once.
REQ-026 M=-32, Q=-32 -> result=12'h400 (+1024); M=31, Q=-32 -> result=12'hC20 (-992).
REQ-027 M=0, Q=-1 -> result=12'h000; M=-1, Q=-1 -> result=12'h001.
REQ-028 A second start pulse during CALC with different operands -> ignored; the first product completes unchanged on schedule.
REQ-029 n_rst asserted during CALC -> result=0 and busy=0 immediately; a later start gives the correct product.
